// File: rtl/sat_bin_host_loader_if.sv
// rtl/sat_bin_host_loader_if.sv - host word stream and result stream bundle for the sat_bin loader
interface sat_bin_host_loader_if #(
  parameter int WIDTH_HOST = 32
);
  logic [WIDTH_HOST-1:0] host_data_i;
  logic                  host_valid_i;
  logic                  host_ready_o;
  logic [WIDTH_HOST-1:0] res_data_o;
  logic                  res_valid_o;
  logic                  res_ready_i;

  modport master (
    output host_data_i, host_valid_i, res_ready_i,
    input  host_ready_o, res_data_o, res_valid_o
  );

  modport slave (
    input  host_data_i, host_valid_i, res_ready_i,
    output host_ready_o, res_data_o, res_valid_o
  );
endinterface

// File: rtl/sat_bin_host_loader.sv
// rtl/sat_bin_host_loader.sv - host stream to sat_bin RAM/bin-info/start loader; SAT_BIN_LOADER_CNT_EN adds a solve-cycle counter
module sat_bin_host_loader #(
  parameter int WIDTH_HOST       = 32,
  parameter int WIDTH_VAR        = 12,
  parameter int WIDTH_CLAUSES    = 16,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 11,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  sat_bin_host_loader_if.slave        host_if,
  output logic                        err_o,
  output logic                        apply_ex_o,
  output logic                        ram_we_v_o,
  output logic [WIDTH_VAR-1:0]        ram_din_v_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_v_o,
  output logic                        ram_we_c_o,
  output logic [WIDTH_CLAUSES-1:0]    ram_din_c_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_c_o,
  output logic                        ram_we_vs_o,
  output logic [WIDTH_VAR_STATES-1:0] ram_din_vs_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_vs_o,
  output logic                        ram_we_ls_o,
  output logic [WIDTH_LVL_STATES-1:0] ram_din_ls_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_ls_o,
  output logic                        bin_info_en_o,
  output logic [WIDTH_VAR-1:0]        nv_all_o,
  output logic [WIDTH_CLAUSES-1:0]    nb_all_o,
  output logic                        start_o,
  input  logic                        done_i,
  input  logic                        global_sat_i,
  input  logic                        global_unsat_i
);
  localparam int WA = (WIDTH_VAR > WIDTH_CLAUSES) ? WIDTH_VAR : WIDTH_CLAUSES;
  localparam int WB = (WIDTH_VAR_STATES > WIDTH_LVL_STATES) ? WIDTH_VAR_STATES : WIDTH_LVL_STATES;
  localparam int WD = (WA > WB) ? WA : WB;

  typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_BININFO, S_BIN_WR, S_START, S_REPORT} state_t;

  state_t                 state_q, state_d;
  logic                   alive_q;
  logic [1:0]             tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d, waddr_q, waddr_d;
  logic [9:0]             rem_q, rem_d;
  logic [WD-1:0]          wdata_q, wdata_d;
  logic [3:0]             we_q, we_d;
  logic                   apply_q, apply_d, err_q, err_d, bin_en_q, bin_en_d;
  logic                   sat_q, sat_d, unsat_q, unsat_d;
  logic [WIDTH_VAR-1:0]     nv_q, nv_d;
  logic [WIDTH_CLAUSES-1:0] nb_q, nb_d;

  logic       accept, start_acc;
  logic [3:0] hdr_cmd;
  logic [9:0] hdr_cnt;

  assign hdr_cmd = host_if.host_data_i[31:28];
  assign hdr_cnt = host_if.host_data_i[27:18];

  // alive_q keeps host_ready_o low while reset is held and on the first edge after release
  assign host_if.host_ready_o = alive_q &&
      (state_q == S_IDLE || state_q == S_PAYLOAD || state_q == S_BININFO);
  assign accept    = host_if.host_valid_i && host_if.host_ready_o;
  assign start_acc = accept && (state_q == S_IDLE) && (hdr_cmd == 4'd5);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 4'b0000;
    apply_d  = apply_q;
    err_d    = err_q;
    bin_en_d = 1'b0;
    nv_d     = nv_q;
    nb_d     = nb_q;
    sat_d    = sat_q;
    unsat_d  = unsat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (hdr_cmd)
            4'd0, 4'd1, 4'd2, 4'd3: begin
              if (hdr_cnt != 10'd0) begin
                tgt_d   = hdr_cmd[1:0];
                ptr_d   = ADDR_WIDTH'(host_if.host_data_i[9:0]);
                rem_d   = hdr_cnt;
                apply_d = 1'b1;
                state_d = S_PAYLOAD;
              end
            end
            4'd4: state_d = S_BININFO;
            4'd5: begin
              apply_d = 1'b0;
              state_d = S_START;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          we_d    = 4'b0001 << tgt_q;
          wdata_d = host_if.host_data_i[WD-1:0];
          waddr_d = ptr_q;
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 10'd1;
          if (rem_q == 10'd1) state_d = S_IDLE;
        end
      end
      S_BININFO: begin
        if (accept) begin
          nv_d     = host_if.host_data_i[WIDTH_VAR-1:0];
          nb_d     = host_if.host_data_i[16 +: WIDTH_CLAUSES];
          bin_en_d = 1'b1;
          state_d  = S_BIN_WR;
        end
      end
      S_BIN_WR: state_d = S_IDLE;
      S_START: begin
        if (done_i) begin
          sat_d   = global_sat_i;
          unsat_d = global_unsat_i;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (host_if.res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      alive_q  <= 1'b0;
      tgt_q    <= '0;
      ptr_q    <= '0;
      rem_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      apply_q  <= 1'b0;
      err_q    <= 1'b0;
      bin_en_q <= 1'b0;
      nv_q     <= '0;
      nb_q     <= '0;
      sat_q    <= 1'b0;
      unsat_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      tgt_q    <= tgt_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      apply_q  <= apply_d;
      err_q    <= err_d;
      bin_en_q <= bin_en_d;
      nv_q     <= nv_d;
      nb_q     <= nb_d;
      sat_q    <= sat_d;
      unsat_q  <= unsat_d;
    end
  end

`ifdef SAT_BIN_LOADER_CNT_EN
  logic [23:0] cnt_q;

  // Counts cycles with start_o high, including the cycle done_i is sampled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        cnt_q <= '0;
    else if (start_acc)                              cnt_q <= '0;
    else if (state_q == S_START && cnt_q != 24'hFFFFFF) cnt_q <= cnt_q + 24'd1;
  end

  assign host_if.res_data_o = WIDTH_HOST'({cnt_q, 5'd0, err_q, unsat_q, sat_q});
`else
  logic unused_start_acc;
  assign unused_start_acc   = start_acc;
  assign host_if.res_data_o = WIDTH_HOST'({5'd0, err_q, unsat_q, sat_q});
`endif

  assign host_if.res_valid_o = (state_q == S_REPORT);
  assign start_o       = (state_q == S_START);
  assign err_o         = err_q;
  assign apply_ex_o    = apply_q;
  assign bin_info_en_o = bin_en_q;
  assign nv_all_o      = nv_q;
  assign nb_all_o      = nb_q;

  assign ram_we_v_o    = we_q[0];
  assign ram_we_c_o    = we_q[1];
  assign ram_we_vs_o   = we_q[2];
  assign ram_we_ls_o   = we_q[3];
  assign ram_din_v_o   = wdata_q[WIDTH_VAR-1:0];
  assign ram_din_c_o   = wdata_q[WIDTH_CLAUSES-1:0];
  assign ram_din_vs_o  = wdata_q[WIDTH_VAR_STATES-1:0];
  assign ram_din_ls_o  = wdata_q[WIDTH_LVL_STATES-1:0];
  assign ram_addr_v_o  = waddr_q;
  assign ram_addr_c_o  = waddr_q;
  assign ram_addr_vs_o = waddr_q;
  assign ram_addr_ls_o = waddr_q;
endmodule

// File: tb/tb_sat_bin_host_loader.sv
// tb/tb_sat_bin_host_loader.sv - directed self-checking bench for sat_bin_host_loader
module tb_sat_bin_host_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sat_bin_host_loader_if #(.WIDTH_HOST(32)) hif();

  logic        err_o, apply_ex_o, bin_info_en_o, start_o;
  logic        ram_we_v_o, ram_we_c_o, ram_we_vs_o, ram_we_ls_o;
  logic [11:0] ram_din_v_o;
  logic [15:0] ram_din_c_o;
  logic [18:0] ram_din_vs_o;
  logic [10:0] ram_din_ls_o;
  logic [9:0]  ram_addr_v_o, ram_addr_c_o, ram_addr_vs_o, ram_addr_ls_o;
  logic [11:0] nv_all_o;
  logic [15:0] nb_all_o;
  logic        done_i, global_sat_i, global_unsat_i;

  sat_bin_host_loader dut (
    .clk(clk), .rst(rst), .host_if(hif),
    .err_o(err_o), .apply_ex_o(apply_ex_o),
    .ram_we_v_o(ram_we_v_o), .ram_din_v_o(ram_din_v_o), .ram_addr_v_o(ram_addr_v_o),
    .ram_we_c_o(ram_we_c_o), .ram_din_c_o(ram_din_c_o), .ram_addr_c_o(ram_addr_c_o),
    .ram_we_vs_o(ram_we_vs_o), .ram_din_vs_o(ram_din_vs_o), .ram_addr_vs_o(ram_addr_vs_o),
    .ram_we_ls_o(ram_we_ls_o), .ram_din_ls_o(ram_din_ls_o), .ram_addr_ls_o(ram_addr_ls_o),
    .bin_info_en_o(bin_info_en_o), .nv_all_o(nv_all_o), .nb_all_o(nb_all_o),
    .start_o(start_o), .done_i(done_i), .global_sat_i(global_sat_i),
    .global_unsat_i(global_unsat_i)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0]  t;
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];
  int  multi_we = 0;
  int  bin_pulses = 0;

  always @(negedge clk) begin
    if (ram_we_v_o)  wq.push_back('{2'd0, ram_addr_v_o,  32'(ram_din_v_o)});
    if (ram_we_c_o)  wq.push_back('{2'd1, ram_addr_c_o,  32'(ram_din_c_o)});
    if (ram_we_vs_o) wq.push_back('{2'd2, ram_addr_vs_o, 32'(ram_din_vs_o)});
    if (ram_we_ls_o) wq.push_back('{2'd3, ram_addr_ls_o, 32'(ram_din_ls_o)});
    if (int'(ram_we_v_o) + int'(ram_we_c_o) + int'(ram_we_vs_o) + int'(ram_we_ls_o) > 1)
      multi_we++;
    if (bin_info_en_o) bin_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    hif.host_data_i  = w;
    hif.host_valid_i = 1'b1;
    while (hif.host_ready_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL send_timeout: ready=%b required 1 within 100 cycles", hif.host_ready_o);
    end
    step();
    hif.host_valid_i = 1'b0;
  endtask

  task automatic check_writes(input string name, input int n, input logic [1:0] t,
                              input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    logic [9:0]  ea[3];
    logic [31:0] ed[3];
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    ed[0] = d0; ed[1] = d1; ed[2] = d2;
    vectors++;
    if (wq.size() != n || multi_we != 0) begin
      miscompares++;
      $display("FAIL %s_count: writes=%0d multi=%0d required %0d and 0", name, wq.size(), multi_we, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (wq[i].t !== t || wq[i].a !== ea[i] || wq[i].d !== ed[i]) begin
          miscompares++;
          $display("FAIL %s_w%0d: tgt=%0d addr=%0d din=%h required tgt=%0d addr=%0d din=%h",
                   name, i, wq[i].t, wq[i].a, wq[i].d, t, ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({hif.host_ready_o, hif.res_valid_o, hif.res_data_o, err_o, apply_ex_o, start_o,
         bin_info_en_o, ram_we_v_o, ram_we_c_o, ram_we_vs_o, ram_we_ls_o, nv_all_o, nb_all_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b res_valid=%b res=%h err=%b apply=%b start=%b required all 0",
               hif.host_ready_o, hif.res_valid_o, hif.res_data_o, err_o, apply_ex_o, start_o);
    end
    step();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (hif.host_ready_o !== 1'b1 || apply_ex_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready: ready=%b apply=%b required 1 0", hif.host_ready_o, apply_ex_o);
    end
  endtask

  task automatic test_vars();
    wq.delete(); multi_we = 0;
    send({4'd0, 10'd3, 8'd0, 10'd5});
    send(32'h0000_000A);
    send(32'h0000_000B);
    send(32'h0000_000C);
    step(); step();
    check_writes("vars", 3, 2'd0, 10'd5, 10'd6, 10'd7, 32'hA, 32'hB, 32'hC);
    vectors++;
    if (apply_ex_o !== 1'b1) begin
      miscompares++;
      $display("FAIL vars_apply: apply=%b required 1", apply_ex_o);
    end
    wq.delete();
    send({4'd1, 10'd0, 8'd0, 10'd9});
    step(); step();
    vectors++;
    if (wq.size() != 0 || hif.host_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL count0: writes=%0d ready=%b required 0 1", wq.size(), hif.host_ready_o);
    end
  endtask

  task automatic test_gapped_wrap();
    wq.delete(); multi_we = 0;
    send({4'd2, 10'd3, 8'd0, 10'd1022});
    send(32'hFFF8_0001);
    step(); step();
    send(32'h0001_2345);
    step();
    send(32'h0007_FFFF);
    step(); step();
    check_writes("vs_wrap", 3, 2'd2, 10'd1022, 10'd1023, 10'd0, 32'h1, 32'h12345, 32'h7FFFF);
  endtask

  task automatic test_bininfo();
    bin_pulses = 0;
    send(32'h4000_0000);
    send(32'h0040_0123);
    vectors++;
    if (bin_info_en_o !== 1'b1 || nv_all_o !== 12'h123 || nb_all_o !== 16'h0040 || hif.host_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bininfo_write: en=%b nv=%h nb=%h ready=%b required 1 123 0040 0",
               bin_info_en_o, nv_all_o, nb_all_o, hif.host_ready_o);
    end
    step(); step();
    vectors++;
    if (bin_info_en_o !== 1'b0 || bin_pulses != 1 || nv_all_o !== 12'h123 || nb_all_o !== 16'h0040) begin
      miscompares++;
      $display("FAIL bininfo_hold: en=%b pulses=%0d nv=%h nb=%h required 0 1 123 0040",
               bin_info_en_o, bin_pulses, nv_all_o, nb_all_o);
    end
  endtask

  task automatic test_stray_done();
    done_i = 1'b1; global_sat_i = 1'b1;
    step();
    done_i = 1'b0; global_sat_i = 1'b0;
    step();
    vectors++;
    if (hif.res_valid_o !== 1'b0 || start_o !== 1'b0 || hif.host_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_done: res_valid=%b start=%b ready=%b required 0 0 1",
               hif.res_valid_o, start_o, hif.host_ready_o);
    end
  endtask

  task automatic test_start(input string name, input logic e_err, input logic g_sat, input logic g_unsat);
    logic [7:0] exp_lo;
    int         low_start;
    exp_lo = {5'd0, e_err, g_unsat, g_sat};
    low_start = 0;
    send(32'h5000_0000);
    vectors++;
    if (start_o !== 1'b1 || apply_ex_o !== 1'b0 || hif.host_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_entry: start=%b apply=%b ready=%b required 1 0 0", name, start_o, apply_ex_o, hif.host_ready_o);
    end
    for (int i = 0; i < 49; i++) begin
      step();
      if (start_o !== 1'b1) low_start++;
    end
    vectors++;
    if (low_start != 0) begin
      miscompares++;
      $display("FAIL %s_start_held: low cycles=%0d required 0", name, low_start);
    end
    done_i = 1'b1; global_sat_i = g_sat; global_unsat_i = g_unsat;
    step();
    done_i = 1'b0; global_sat_i = 1'b0; global_unsat_i = 1'b0;
    hif.res_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (hif.res_valid_o !== 1'b1 || start_o !== 1'b0 || hif.res_data_o[7:0] !== exp_lo) begin
        miscompares++;
        $display("FAIL %s_report%0d: valid=%b start=%b res=%h required 1 0 low %h",
                 name, i, hif.res_valid_o, start_o, hif.res_data_o, exp_lo);
      end
`ifdef SAT_BIN_LOADER_CNT_EN
      vectors++;
      if (hif.res_data_o[31:8] < 24'd49 || hif.res_data_o[31:8] > 24'd51) begin
        miscompares++;
        $display("FAIL %s_cnt%0d: cnt=%0d required 49..51", name, i, hif.res_data_o[31:8]);
      end
`else
      vectors++;
      if (hif.res_data_o[31:8] !== 24'd0) begin
        miscompares++;
        $display("FAIL %s_upper%0d: upper=%h required 0", name, i, hif.res_data_o[31:8]);
      end
`endif
      step();
    end
    hif.res_ready_i = 1'b1;
    step();
    hif.res_ready_i = 1'b0;
    vectors++;
    if (hif.res_valid_o !== 1'b0 || hif.host_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_release: valid=%b ready=%b required 0 1", name, hif.res_valid_o, hif.host_ready_o);
    end
  endtask

  task automatic test_illegal();
    wq.delete(); multi_we = 0;
    send(32'hF000_0000);
    step();
    vectors++;
    if (err_o !== 1'b1 || wq.size() != 0 || hif.host_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_cmd: err=%b writes=%0d ready=%b required 1 0 1", err_o, wq.size(), hif.host_ready_o);
    end
    test_start("err_start", 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_payload();
    wq.delete(); multi_we = 0;
    send({4'd0, 10'd4, 8'd0, 10'd100});
    send(32'h0000_0011);
    hif.host_data_i  = 32'h0000_0022;
    hif.host_valid_i = 1'b1;
    #5;
    rst = 1'b0;
    #1;
    vectors++;
    if ({hif.host_ready_o, hif.res_valid_o, hif.res_data_o, err_o, apply_ex_o, start_o, bin_info_en_o,
         ram_we_v_o, ram_we_c_o, ram_we_vs_o, ram_we_ls_o, ram_din_v_o, ram_addr_v_o, nv_all_o, nb_all_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: ready=%b err=%b apply=%b we_v=%b addr=%0d nv=%h required all 0",
               hif.host_ready_o, err_o, apply_ex_o, ram_we_v_o, ram_addr_v_o, nv_all_o);
    end
    hif.host_valid_i = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check_writes("pre_reset", 1, 2'd0, 10'd100, 10'd0, 10'd0, 32'h11, 32'h0, 32'h0);
    wq.delete();
    send({4'd0, 10'd1, 8'd0, 10'd0});
    send(32'h0000_0055);
    step(); step();
    check_writes("post_reset", 1, 2'd0, 10'd0, 10'd0, 10'd0, 32'h55, 32'h0, 32'h0);
  endtask

  initial begin
    hif.host_data_i  = '0;
    hif.host_valid_i = 1'b0;
    hif.res_ready_i  = 1'b0;
    done_i = 1'b0; global_sat_i = 1'b0; global_unsat_i = 1'b0;
    test_reset();
    test_vars();
    test_gapped_wrap();
    test_bininfo();
    test_stray_done();
    test_start("sat_start", 1'b0, 1'b1, 1'b0);
    test_illegal();
    test_reset_mid_payload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sat_bin_host_loader.md
Name: sat_bin_host_loader

Overview:
Host-side initiator that drives the external load/control port set of the sat_bin top. It parses a host word stream of headers plus payload into per-cycle RAM writes for four targets: vars bins, clauses bins, var states and lvl states. It also drives bin info, launches solving, waits for done, and returns one result word on an output stream. It owns `apply_ex_o` so the external writers have exclusive RAM access while loading.

Parameters:
- WIDTH_HOST, 32, host stream word width.
- WIDTH_VAR, 12, vars-bin RAM data width and nv_all width.
- WIDTH_CLAUSES, 16, clauses-bin RAM data width and nb_all width.
- WIDTH_VAR_STATES, 19, var-states RAM data width.
- WIDTH_LVL_STATES, 11, lvl-states RAM data width.
- ADDR_WIDTH, 10, address width shared by all four RAM targets.

Ports:
- clk  in  1  clock
- rst  in  1  reset (asynchronous, active-low)
- host_data_i  in  WIDTH_HOST  header/payload word
- host_valid_i  in  1  word valid
- host_ready_o  out  1  word accepted when valid&&ready
- res_data_o  out  WIDTH_HOST  result word
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed when valid&&ready
- err_o  out  1  sticky bad-command flag
- apply_ex_o  out  1  external port ownership
- ram_we_v_o / ram_din_v_o / ram_addr_v_o  out  1 / WIDTH_VAR / ADDR_WIDTH  vars-bin write
- ram_we_c_o / ram_din_c_o / ram_addr_c_o  out  1 / WIDTH_CLAUSES / ADDR_WIDTH  clauses-bin write
- ram_we_vs_o / ram_din_vs_o / ram_addr_vs_o  out  1 / WIDTH_VAR_STATES / ADDR_WIDTH  var-states write
- ram_we_ls_o / ram_din_ls_o / ram_addr_ls_o  out  1 / WIDTH_LVL_STATES / ADDR_WIDTH  lvl-states write
- bin_info_en_o / nv_all_o / nb_all_o  out  1 / WIDTH_VAR / WIDTH_CLAUSES  bin info
- start_o  out  1  solve request
- done_i / global_sat_i / global_unsat_i  in  1 each  solver completion and result

Behaviour:
- Reset: all outputs 0. FSM enters IDLE. Address counter, payload counter and err_o are cleared.
- Header fields:
  - cmd = [31:28]
  - count = [27:18] (payload words, 0..1023)
  - base = [9:0]
- Commands:
  - 0 = vars
  - 1 = clauses
  - 2 = var states
  - 3 = lvl states
  - 4 = bin info
  - 5 = start
  - other = illegal
- IDLE: host_ready_o=1.
  - On an accepted header with cmd 0-3: latch target, base and count; set apply_ex_o=1; go to PAYLOAD. If count=0, stay in IDLE with no writes.
  - cmd 4: go to BININFO.
  - cmd 5: go to START.
  - Illegal cmd: set err_o, stay in IDLE. The word is consumed.
- PAYLOAD: host_ready_o=1.
  - Each accepted word produces, on the next cycle, exactly one we pulse on the latched target. din is the payload LSBs truncated to the target width; addr is base+k mod 2^ADDR_WIDTH (wraps 1023 -> 0).
  - Throughput is 1 write per cycle; gaps in host_valid_i produce no writes.
  - After the count-th word is accepted, return to IDLE.
  - All we of non-selected targets stay 0.
- BININFO: accepts one payload word. Next cycle: nv_all_o=[WIDTH_VAR-1:0], nb_all_o=[31:16], bin_info_en_o pulses 1 cycle. nv_all_o and nb_all_o hold their values afterwards. Return to IDLE.
- START:
  - apply_ex_o drops to 0 in the same cycle start_o rises.
  - host_ready_o=0.
  - start_o is held at 1 until done_i=1 is sampled. At that sample, capture global_sat_i and global_unsat_i, clear start_o, and go to REPORT.
- REPORT:
  - res_valid_o=1 with res_data_o[0]=sat, [1]=unsat, [2]=err_o, [7:3]=0.
  - res_data_o holds stable under backpressure.
  - On res_ready_i, clear res_valid_o and return to IDLE. err_o persists.
- host_ready_o=0 in BININFO-write cycle, START, WAIT_DONE and REPORT.
- A done_i pulse arriving outside START/WAIT_DONE is ignored.
- Asynchronous reset mid-PAYLOAD aborts the load. No further we pulses occur after reset asserts.

Optional Feature:
Macro SAT_BIN_LOADER_CNT_EN.
- Defined: a 24-bit counter clears when start_o rises and increments each cycle until done_i is sampled, saturating at 24'hFFFFFF. It is reported in res_data_o[31:8].
- Undefined: res_data_o[31:8]=0 and no counter logic exists.

Test Plan:
- Header {cmd0, count3, base5}, then payloads 0xA, 0xB, 0xC on consecutive cycles -> ram_we_v_o pulses at addr 5/6/7 with din 0xA/0xB/0xC. apply_ex_o=1 and no other we asserted.
- Header {cmd2, count3, base1022} with gapped valid -> ram_we_vs_o at addr 1022, 1023, 0, one pulse per accepted word only.
- Header cmd4, payload 0x0040_0123 -> bin_info_en_o 1-cycle pulse, nv_all_o=0x123, nb_all_o=0x0040.
- cmd5; done_i=1 with global_sat_i=1 after 50 cycles; res_ready_i=0 for 4 cycles -> start_o high until done, apply_ex_o=0, res_data_o[1:0]=2'b01 held stable, [31:8]=50±1 with CNT_EN.
- Header cmd 0xF -> err_o=1, no writes. A subsequent start then reports res_data_o[2]=1.
- rst low during 2nd payload of a count-4 load -> all outputs 0 immediately. After release, a new header is accepted in IDLE.
